uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, default frame geometry and parity mode.
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    // 1'b0 selects even parity: the parity bit makes the total count of ones even.
    localparam logic UART_PARITY_ODD = 1'b0;

    // Encodings are fixed so they stay the same with or without the parity build.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset
// to the idle level (1) so leaving reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk_sis,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    always_ff @(posedge clk_sis or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start + DATA_BITS (LSB first) [+ even parity] + stop, sampled at bit centres.
// Optional parity bit and parity_err output are enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk_sis,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy,
    output uart_state_e          state_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [BW-1:0]        bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [DATA_BITS-1:0] data_nx;
    logic                 valid_nx, ferr_nx;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_nx;
    logic                 perr_nx;
`endif

    uart_rx_sync u_sync (
        .clk_sis (clk_sis),
        .rst     (rst),
        .rx      (rx),
        .rx_s    (rx_s)
    );

    always_ff @(posedge clk_sis or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            bit_cnt    <= bit_nx;
            shift      <= shift_nx;
            data_out   <= data_nx;
            data_valid <= valid_nx;
            frame_err  <= ferr_nx;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_nx;
            parity_err <= perr_nx;
`endif
        end
    end

    // The baud counter restarts at every transition, so each state times its own interval.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_cnt;
        shift_nx = shift;
        data_nx  = data_out;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nx = par_bad;
        perr_nx    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx = ST_START;
                    cnt_nx   = '0;
                    bit_nx   = '0;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    bit_nx   = '0;
                    state_nx = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    shift_nx = {rx_s, shift[DATA_BITS-1:1]};
                    bit_nx   = bit_cnt + 1'b1;
                    if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = ST_PARITY;
`else
                        state_nx = ST_STOP;
`endif
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx     = '0;
                    par_bad_nx = (rx_s != ((^shift) ^ UART_PARITY_ODD));
                    state_nx   = ST_STOP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
`ifdef UART_RX_PARITY_EN
                    perr_nx = par_bad;
`endif
                    if (rx_s) begin
                        data_nx  = shift;
                        valid_nx = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // Line held low (break) must return high before a new start is accepted.
                if (rx_s) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic against a
// frame-level timing/data model; define UART_RX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int C  = 16;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Sync delay + half bit + full bits up to the stop sample + one registered pulse.
    localparam int LAT = 2 + C / 2 + (DB + 1 + PB) * C + 1;

    logic          clk_sis;
    logic          rst;
    logic          rx;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;
    uart_state_e   state_dbg;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Scoreboard: one entry per expected pulse, in time order.
    logic [DB-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic          exp_kind_q[$];   // 0 = data_valid, 1 = frame_err
    logic          exp_perr_q[$];
    logic [DB-1:0] model_dout;

    uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk_sis    (clk_sis),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_sis = 1'b0;
        forever #5 clk_sis = ~clk_sis;
    end

    always @(posedge clk_sis) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d events pending", exp_cyc_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks (entered and left #1 after a rising edge) ----------------
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (C) @(posedge clk_sis);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk_sis);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state"}, state_dbg, ST_IDLE);
`ifdef UART_RX_PARITY_EN
        check({tag, "_parity_err"}, parity_err, 0);
`endif
    endtask

    // abort_bit >= 0: pulse reset for 3 cycles in the middle of that data bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                              input logic par_bit, input int abort_bit);
        int fall;
        fall = cyc;
        if (abort_bit < 0) begin
            exp_kind_q.push_back(!stop_bit);
            exp_cyc_q.push_back(fall + LAT);
            exp_q.push_back(stop_bit ? d : model_dout);
            exp_perr_q.push_back((PB != 0) && (par_bit != (^d)));
            if (stop_bit) model_dout = d;
        end
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) begin
            if (i == abort_bit) begin
                rx = d[i];
                repeat (C / 2) @(posedge clk_sis);
                #1;
                rst = 1'b0;
                rx  = 1'b1;
                model_dout = '0;
                @(negedge clk_sis);
                check_reset_values("midframe_reset");
                repeat (3) @(posedge clk_sis);
                #1;
                rst = 1'b1;
                return;
            end
            drive_bit(d[i]);
        end
        if (PB != 0) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [DB-1:0] m_data;
    int            m_cyc;
    logic          m_kind;
    logic          m_perr;

    always @(negedge clk_sis) begin
        if (rst && (data_valid || frame_err)) begin
            check("valid_ferr_exclusive", data_valid & frame_err, 0);
            if (exp_cyc_q.size() == 0) begin
                check("unexpected_pulse", data_valid | frame_err, 0);
            end else begin
                m_kind = exp_kind_q.pop_front();
                m_cyc  = exp_cyc_q.pop_front();
                m_data = exp_q.pop_front();
                m_perr = exp_perr_q.pop_front();
                check("pulse_kind_ferr", frame_err, m_kind);
                check("pulse_cycle", cyc, m_cyc);
                check("data_out", data_out, m_data);
`ifdef UART_RX_PARITY_EN
                check("parity_err", parity_err, m_perr);
`endif
            end
        end
`ifdef UART_RX_PARITY_EN
        if (rst && parity_err && !(data_valid || frame_err))
            check("lone_parity_err", parity_err, 0);
`endif
    end

    // ---------------- stimulus ----------------
    int   fall;
    logic prev_bad;
    logic [DB-1:0] rd;
    logic rstop, rpar;

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        model_dout = '0;
        @(negedge clk_sis);
        check_reset_values("reset");
        @(posedge clk_sis);
        #1;
        rst = 1'b1;
        idle(5);
        check_reset_values("post_reset_idle");

        // Single good frame, then two back-to-back frames 160 cycles apart.
        send_frame(8'hA5, 1'b1, ^8'hA5, -1);
        idle(7);
        send_frame(8'h3C, 1'b1, ^8'h3C, -1);
        send_frame(8'hFF, 1'b1, ^8'hFF, -1);
        idle(20);

        // 4-cycle low glitch on an idle line.
        fall = cyc;
        rx = 1'b0;
        repeat (4) @(posedge clk_sis);
        #1;
        rx = 1'b1;
        check("glitch_busy_high", busy, 1);
        while (cyc < fall + 12) @(posedge clk_sis);
        #1;
        check("glitch_busy_cleared", busy, 0);
        idle(10);

        // Stop bit low, line held low 40 more cycles (break), then released.
        fall = cyc;
        send_frame(8'h55, 1'b0, ^8'h55, -1);
        rx = 1'b0;
        repeat (40) @(posedge clk_sis);
        #1;
        check("break_busy_held", busy, 1);
        rx = 1'b1;
        @(posedge clk_sis);
        #1;
        check("break_busy_still", busy, 1);
        repeat (2) @(posedge clk_sis);
        #1;
        check("break_busy_released", busy, 0);
        idle(10);

        // Reset during data bit 4 of 0x81, then a clean 0x12.
        send_frame(8'h81, 1'b1, ^8'h81, 4);
        idle(10);
        check_reset_values("after_abort");
        send_frame(8'h12, 1'b1, ^8'h12, -1);
        idle(10);

`ifdef UART_RX_PARITY_EN
        // Wrong even-parity bit on 0x07: parity_err alongside data_valid.
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(10);
`endif

        // Randomized traffic: random data, occasional bad stop / bad parity, random gaps.
        prev_bad = 1'b0;
        for (int n = 0; n < 24; n++) begin
            rd    = DB'($urandom_range(0, (1 << DB) - 1));
            rstop = ($urandom_range(0, 5) != 0);
            rpar  = (^rd) ^ ($urandom_range(0, 3) == 0);
            if (prev_bad || ($urandom_range(0, 2) != 0))
                idle($urandom_range(1, 20));
            send_frame(rd, rstop, rpar, -1);
            prev_bad = !rstop;
        end
        idle(2);

        for (int i = 0; i < LAT + 200 && exp_cyc_q.size() != 0; i++) @(posedge clk_sis);
        @(negedge clk_sis);
        check("events_left", exp_cyc_q.size(), 0);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
